// File: rtl/wb_burst_prefetch.sv
// Wishbone B3 burst read master that prefetches a run of words into a local FWFT FIFO.
// Bursts are sized to stay inside a BURST-aligned window and to fit the free FIFO space.
module wb_burst_prefetch #(
    parameter int unsigned ADDRESS   = 23,
    parameter int unsigned BURST     = 16,
    parameter int unsigned FIFO_LOG2 = 5,
    parameter int unsigned COUNT     = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [ADDRESS-1:0]   base_i,
    input  logic [COUNT-1:0]     words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [2:0]           wb_cti_o,
    output logic [1:0]           wb_bte_o,
    output logic [ADDRESS-1:0]   wb_adr_o,
    output logic [3:0]           wb_sel_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_rty_i,
    input  logic                 wb_err_i,
    input  logic [31:0]          wb_dat_i,
    input  logic                 rd_i,
    output logic [31:0]          dat_o,
    output logic                 empty_o,
    output logic [FIFO_LOG2:0]   level_o
);

    localparam int unsigned BW    = $clog2(BURST);
    localparam int unsigned LW    = BW + 1;
    localparam int unsigned LVW   = FIFO_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BURST} state_t;

    state_t               state_q, state_d;
    logic [ADDRESS-1:0]   adr_q, adr_d;
    logic [COUNT-1:0]     rem_q, rem_d;
    logic [LW-1:0]        beats_q, beats_d;
    logic [2:0]           cti_q, cti_d;
    logic                 cyc_q, cyc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 push, pop, fits;
    logic [LW-1:0]        room, len;
    logic [LVW-1:0]       level_q, free;
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [31:0]          mem [DEPTH];

    // Burst length is capped by the distance to the next BURST boundary.
    assign room = LW'(BURST) - LW'(adr_q[BW-1:0]);
    assign len  = (COUNT'(room) > rem_q) ? LW'(rem_q) : room;
    assign free = LVW'(DEPTH) - level_q;
    assign fits = 32'(free) >= 32'(len);
    assign pop  = rd_i && (level_q != '0);

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        cti_d   = cti_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    adr_d = base_i;
                    rem_d = words_i;
                    if (words_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fits) begin
                    state_d = S_BURST;
                    cyc_d   = 1'b1;
                    beats_d = len;
                    cti_d   = (len == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
                end
            end
            S_BURST: begin
                // The CHECK cycle after a retry is the one-cycle bus release.
                if (cyc_q && wb_err_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cyc_q && wb_rty_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    state_d = S_CHECK;
                end else if (cyc_q && wb_ack_i) begin
                    push    = 1'b1;
                    adr_d   = adr_q + ADDRESS'(1);
                    rem_d   = rem_q - COUNT'(1);
                    beats_d = beats_q - LW'(1);
                    if (beats_q == LW'(1)) begin
                        cyc_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (rem_q == COUNT'(1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else if (beats_q == LW'(2)) begin
                        cti_d = CTI_END;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            cti_q   <= CTI_CLASSIC;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            cti_q   <= cti_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // FIFO storage; no overflow guard since bursts are admitted only into free space.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVW'(1);
                2'b01:   level_q <= level_q - LVW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = 1'b0;
    assign wb_cti_o = cti_q;
    assign wb_bte_o = 2'b00;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = 4'b1111;
    assign dat_o    = mem[rd_ptr];
    assign empty_o  = (level_q == '0);
    assign level_o  = level_q;

endmodule

// File: tb/tb_wb_burst_prefetch.sv
// Bench for wb_burst_prefetch: random Wishbone slave, random consumer, and a queue-based
// reference model of the fetched word stream and burst schedule.
module tb_wb_burst_prefetch;

    localparam int unsigned ADDRESS   = 23;
    localparam int unsigned BURST     = 16;
    localparam int unsigned FIFO_LOG2 = 5;
    localparam int unsigned COUNT     = 16;
    localparam int unsigned DEPTH     = 32;
    localparam int unsigned AMASK     = (1 << ADDRESS) - 1;

    logic                 clk = 1'b0;
    logic                 wb_rst_i, start_i, busy_o, done_o, err_o;
    logic [ADDRESS-1:0]   base_i, wb_adr_o;
    logic [COUNT-1:0]     words_i;
    logic                 wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_rty_i, wb_err_i;
    logic [2:0]           wb_cti_o;
    logic [1:0]           wb_bte_o;
    logic [3:0]           wb_sel_o;
    logic [31:0]          wb_dat_i, dat_o;
    logic                 rd_i, empty_o;
    logic [FIFO_LOG2:0]   level_o;

    always #5 clk = ~clk;

    wb_burst_prefetch #(
        .ADDRESS(ADDRESS), .BURST(BURST), .FIFO_LOG2(FIFO_LOG2), .COUNT(COUNT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i), .base_i(base_i),
        .words_i(words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_rty_i(wb_rty_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i),
        .rd_i(rd_i), .dat_o(dat_o), .empty_o(empty_o), .level_o(level_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] seed;
    bit          m_busy, m_err, after_rty;
    int unsigned fa, rem;
    int          beats_left, cur_len, n_bursts, gap, popped;

    // Stimulus controls
    int          pop_pct, pops_left, ack_pct, fault_kind, fault_beat, rst_beat;
    bit          start_req;
    int unsigned s_base, s_words;

    // What was driven into the last clock edge
    bit          p_rst, p_start, p_cyc, p_ack, p_rty, p_err, p_rd;
    int unsigned p_base, p_words;

    function automatic logic [31:0] mem_word(input int unsigned a);
        return ((a & AMASK) * 32'h9E3779B1) ^ seed;
    endfunction

    task automatic monitor();
        bit          exp_done = 1'b0;
        int unsigned room;
        logic [2:0]  exp_cti;
        if (p_rst) begin
            q.delete();
            m_busy = 0; m_err = 0; beats_left = 0; after_rty = 0;
            chk("rst_cyc", 32'(wb_cyc_o), 0);
            chk("rst_adr", 32'(wb_adr_o), 0);
            chk("rst_cti", 32'(wb_cti_o), 0);
        end else begin
            if (p_start && !m_busy) begin
                m_err = 0; fa = p_base; rem = p_words; n_bursts = 0;
                if (p_words == 0) exp_done = 1'b1;
                else m_busy = 1;
            end
            if (p_cyc) begin
                if (p_err) begin
                    m_err = 1; exp_done = 1'b1; m_busy = 0; beats_left = 0;
                end else if (p_rty) begin
                    beats_left = 0; after_rty = 1;
                end else if (p_ack) begin
                    q.push_back(mem_word(fa));
                    fa = (fa + 1) & AMASK;
                    rem--;
                    beats_left--;
                    if (rem == 0) begin
                        exp_done = 1'b1; m_busy = 0;
                    end
                end
            end
            if (p_rd) begin
                void'(q.pop_front());
                popped++;
            end
        end
        chk("level", 32'(level_o), 32'(q.size()));
        chk("empty", 32'(empty_o), 32'(q.size() == 0));
        chk("done", 32'(done_o), 32'(exp_done));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("err", 32'(err_o), 32'(m_err));
        if (!m_busy) chk("cyc_idle", 32'(wb_cyc_o), 0);
        if (wb_cyc_o && !p_cyc) begin
            if (after_rty) begin
                chk("rty_gap", 32'(gap), 1);
                after_rty = 0;
            end
            room = BURST - (fa % BURST);
            cur_len = (rem < room) ? int'(rem) : int'(room);
            beats_left = cur_len;
            n_bursts++;
            chk("fit", 32'(DEPTH - q.size() >= cur_len), 1);
        end
        if (wb_cyc_o) begin
            gap = 0;
            exp_cti = (cur_len == 1) ? 3'b000 : ((beats_left > 1) ? 3'b010 : 3'b111);
            chk("adr", 32'(wb_adr_o), fa);
            chk("cti", 32'(wb_cti_o), 32'(exp_cti));
            chk("stb", 32'(wb_stb_o), 1);
            chk("overrun", 32'(beats_left > 0), 1);
            chk("static", {25'd0, wb_we_o, wb_bte_o, wb_sel_o}, 32'h0F);
        end else begin
            gap++;
            if (m_busy && beats_left > 0) chk("cyc_drop", 32'(wb_cyc_o), 1);
        end
    endtask

    task automatic drive();
        int bd;
        bit do_rst, want;
        bd = cur_len - beats_left;
        do_rst = 1'b0;
        wb_ack_i = 0; wb_rty_i = 0; wb_err_i = 0;
        wb_dat_i = mem_word(32'(wb_adr_o));
        if (wb_cyc_o && wb_stb_o) begin
            if (rst_beat >= 0 && bd == rst_beat) begin
                do_rst = 1'b1; wb_ack_i = 1; rst_beat = -1;
            end else if (fault_kind != 0 && bd == fault_beat) begin
                wb_ack_i = 1; wb_rty_i = 1; wb_err_i = (fault_kind == 2);
                fault_kind = 0;
            end else begin
                wb_ack_i = ($urandom_range(99) < 32'(ack_pct));
            end
        end else begin
            wb_ack_i = ($urandom_range(7) == 0);
            wb_err_i = ($urandom_range(15) == 0);
        end
        wb_rst_i = do_rst;
        want = (pops_left > 0) || ($urandom_range(99) < 32'(pop_pct));
        rd_i = want;
        p_rd = 0;
        if (want && !do_rst && q.size() > 0) begin
            chk("data", dat_o, q[0]);
            p_rd = 1;
            if (pops_left > 0) pops_left--;
        end
        start_i = start_req;
        base_i  = start_req ? ADDRESS'(s_base) : ADDRESS'($urandom);
        words_i = start_req ? COUNT'(s_words) : COUNT'($urandom);
        p_start = start_req && !do_rst;
        p_base  = s_base & AMASK;
        p_words = s_words;
        start_req = 0;
        p_rst = do_rst;
        p_cyc = wb_cyc_o;
        p_ack = wb_ack_i; p_rty = wb_rty_i; p_err = wb_err_i;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        drive();
    endtask

    task automatic start(input int unsigned b, input int unsigned w);
        s_base = b; s_words = w; start_req = 1;
        cycle();
        cycle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) chk("timeout", 32'(m_busy), 0);
    endtask

    task automatic drain();
        int n = 0;
        pop_pct = 100;
        while (q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        pop_pct = 0;
        cycle();
        chk("drained", 32'(level_o), 0);
    endtask

    initial begin
        int p0, n;
        seed = $urandom;
        wb_rst_i = 1; start_i = 0; base_i = '0; words_i = '0; rd_i = 0;
        wb_ack_i = 0; wb_rty_i = 0; wb_err_i = 0; wb_dat_i = '0;
        pop_pct = 0; pops_left = 0; ack_pct = 100; fault_kind = 0; fault_beat = 0;
        rst_beat = -1; start_req = 0; popped = 0; gap = 0; cur_len = 0;
        @(posedge clk);
        p_rst = 1;
        cycle(); p_rst = 1; wb_rst_i = 1;
        cycle();
        cycle();

        // Aligned 16-word fetch
        start(0, 16);
        wait_idle();
        chk("t1_level", 32'(level_o), 16);
        chk("t1_bursts", 32'(n_bursts), 1);
        drain();

        // Unaligned fetch: bursts of 2, 16, 2
        start(32'h0E, 20);
        wait_idle();
        chk("t2_bursts", 32'(n_bursts), 3);
        chk("t2_level", 32'(level_o), 20);
        drain();

        // Back-pressure with an idle consumer
        p0 = popped;
        start($urandom & 32'h7FFFF0, 48);
        n = 0;
        while (q.size() < 32 && n < 500) begin cycle(); n++; end
        chk("t3_fill", 32'(level_o), 32);
        repeat (20) begin
            cycle();
            chk("bp_hold", 32'(wb_cyc_o), 0);
        end
        pops_left = 16;
        wait_idle();
        chk("t3_level", 32'(level_o), 32);
        drain();
        chk("t3_total", 32'(popped - p0), 48);

        // Retry on beat 5
        fault_kind = 1; fault_beat = 5;
        start(0, 16);
        wait_idle();
        chk("t4_fired", 32'(fault_kind), 0);
        chk("t4_bursts", 32'(n_bursts), 2);
        chk("t4_err", 32'(err_o), 0);
        chk("t4_level", 32'(level_o), 16);
        drain();

        // Error on beat 3, then a fresh start clears err_o; a start while busy is ignored
        fault_kind = 2; fault_beat = 3;
        start(32'h40, 16);
        wait_idle();
        cycle();
        chk("t5_level", 32'(level_o), 3);
        chk("t5_err", 32'(err_o), 1);
        chk("t5_busy", 32'(busy_o), 0);
        start($urandom, 5);
        s_base = 32'h123; s_words = 40; start_req = 1;
        wait_idle();
        chk("t5_level2", 32'(level_o), 8);
        drain();

        // Zero-length fetch
        start($urandom, 0);
        repeat (3) begin
            chk("w0_cyc", 32'(wb_cyc_o), 0);
            cycle();
        end

        // Reset during beat 7
        rst_beat = 7;
        start(0, 16);
        wait_idle();
        cycle();
        chk("t7_level", 32'(level_o), 0);
        chk("t7_cyc", 32'(wb_cyc_o), 0);

        // Randomised fetches with wait states, faults and a consuming reader
        for (int i = 0; i < 8; i++) begin
            ack_pct = 40 + $urandom_range(60);
            pop_pct = 20 + $urandom_range(70);
            fault_kind = ($urandom_range(2) == 0) ? 0 : $urandom_range(1, 2);
            fault_beat = $urandom_range(3);
            start((i == 3) ? 32'h7FFFF9 : $urandom, $urandom_range(1, 60));
            wait_idle();
            fault_kind = 0;
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_burst_prefetch.md
Name: wb_burst_prefetch

Overview:
- Wishbone B3 read master that sits directly upstream of wb_sdram_ctrl and feeds it incrementing bursts.
- Fetches a programmed run of 32-bit words from SDRAM into a local FIFO for a streaming consumer, e.g. the OpenVGA scan-out line buffer.
- Issues only bursts that fit in free FIFO space, so the SDRAM controller never sees a stalled burst.
- Handles rty by re-issuing and err by aborting.

Parameters:
ADDRESS, 23, word-address width (matches the 8Mx32 controller configuration)
BURST, 16, maximum beats per burst; power of two; bursts never cross a BURST-aligned boundary
FIFO_LOG2, 5, log2 of FIFO depth (32 words); depth must be >= BURST
COUNT, 16, width of the word-count input

Ports:
wb_clk_i  in  1  system clock; all logic is on its rising edge
wb_rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle request to begin a fetch; ignored while busy_o=1
base_i  in  ADDRESS  start word address; sampled when start_i is accepted
words_i  in  COUNT  number of words to fetch; sampled when start_i is accepted
busy_o  out  1  high from start acceptance until done_o
done_o  out  1  one-cycle pulse when the fetch completes or aborts
err_o  out  1  sticky bus-error flag; cleared on the next accepted start_i
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  constant 0
wb_cti_o  out  3  cycle type identifier
wb_bte_o  out  2  constant 2'b00 (linear burst)
wb_adr_o  out  ADDRESS  current word address
wb_sel_o  out  4  constant 4'b1111
wb_ack_i  in  1  acknowledge
wb_rty_i  in  1  retry
wb_err_i  in  1  error
wb_dat_i  in  32  read data
rd_i  in  1  consumer pop; ignored when empty_o=1
dat_o  out  32  FIFO head word (first-word fall-through); valid while empty_o=0
empty_o  out  1  FIFO empty
level_o  out  FIFO_LOG2+1  FIFO occupancy, 0..2^FIFO_LOG2

Behaviour:
- Reset values: cyc/stb/busy/done/err = 0, cti = 000, adr = 0, FIFO cleared (empty_o = 1, level_o = 0).
- Reset mid-burst drops cyc/stb at the same edge; an ack arriving in that cycle is discarded.
- States and transitions:
  - IDLE: start_i latches adr <= base_i and rem <= words_i; busy_o = 1; next state CHECK. If words_i = 0, done_o pulses next cycle and the bus is never touched.
  - CHECK: compute len = min(rem, BURST - adr[log2 BURST - 1:0]). If rem = 0, pulse done_o and go to IDLE. If free space (depth - level_o) >= len, go to BURST with beat counter = len; otherwise stay in CHECK.
  - BURST: cyc = stb = 1.
    - cti = 010 while beats remaining > 1, 111 on the last beat; a len = 1 burst uses cti = 000 (classic).
    - Each cycle with ack: push wb_dat_i, adr += 1, rem -= 1, beats -= 1.
    - After the last ack, cyc/stb drop next cycle and the state goes to CHECK.
  - RETRY: entered on rty in BURST. Drop cyc/stb for exactly one cycle, then go to CHECK. No push on the rty cycle; the remainder is re-issued from the current adr.
  - err in BURST: no push, drop cyc/stb, set err_o, pulse done_o, go to IDLE. Already-fetched FIFO data is retained.
- ack/rty/err are considered only while cyc & stb = 1. If several assert in the same cycle, priority is err > rty > ack.
- adr wraps modulo 2^ADDRESS.
- Space check: pushes occur only from a burst admitted with free >= len, and pops only increase free space, so the FIFO never overflows. The push path carries no overflow guard.
- FIFO push and pop in the same cycle: level_o is unchanged, and data order is preserved.
- Pop while empty: no effect. Pop of the last word with a simultaneous push: dat_o shows the new word next cycle.
- start_i while busy_o = 1: ignored, with no effect on the fetch in progress.
- done_o asserts the cycle after the final ack (or the error cycle); busy_o falls together with done_o.

Test Plan:
- Aligned fetch, base=0, words=16, consumer idle:
  - expect one burst of 16 beats, cti 010×15 then 111, adr 0..15;
  - level_o=16; done_o pulses once; the 16 words pop out in order.
- Unaligned fetch, base=0x00000E, words=20: expect bursts of len 2 (adr E–F), then 16 (10–1F), then 2 (20–21), with no burst crossing a 16-word boundary.
- Back-pressure, words=48, consumer never pops:
  - after 32 words, CHECK holds with cyc=0;
  - pop 16 → the next burst starts and level_o reaches 32;
  - pop all → 48 correct words total.
- Retry: slave asserts rty on beat 5 of the first burst → cyc low one cycle, re-issue from adr 5 (len 11), 16 correct words total, err_o=0.
- Error: slave asserts err on beat 3 → err_o=1, done_o pulse, level_o=3, busy_o=0; the next start clears err_o.
- words=0 and reset mid-burst:
  - words=0 → done_o on the next cycle with no cyc;
  - wb_rst_i asserted during beat 7 → cyc=0, level_o=0 the following cycle.
